miriscv_alu_arbiter: RTL and testbench

//  Shares one combinational miriscv ALU between two requesters: 0 = core execute stage, 1 = auxiliary unit (CSR/debug).

---
 rtl/miriscv_alu_arbiter.sv | 119 +++++++++++
 tb/tb_miriscv_alu_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_alu_arbiter.sv
// Two-requester arbiter sharing one external combinational miriscv ALU: IDLE -> EXEC -> RESP.
// Define MIRISCV_ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module miriscv_alu_arbiter #(
  parameter int XLEN         = 32,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                req_valid_i,
  output logic [1:0]                req_ready_o,
  input  logic [2*ALU_OP_WIDTH-1:0] req_op_i,
  input  logic [2*XLEN-1:0]         req_a_i,
  input  logic [2*XLEN-1:0]         req_b_i,
  output logic [ALU_OP_WIDTH-1:0]   alu_op_o,
  output logic [XLEN-1:0]           alu_a_o,
  output logic [XLEN-1:0]           alu_b_o,
  input  logic [XLEN-1:0]           alu_result_i,
  input  logic                      alu_flag_i,
  output logic [1:0]                rsp_valid_o,
  input  logic [1:0]                rsp_ready_i,
  output logic [XLEN-1:0]           rsp_data_o,
  output logic                      rsp_flag_o,
  output logic [1:0]                dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Requesters hold valid/op/a/b until ready; a response holds data/flag until the owner's ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    owner_q;
  logic                    grant_idx;
  logic [1:0]              grant;
  logic                    accept;
  logic                    rsp_done;
  logic [ALU_OP_WIDTH-1:0] op_q;
  logic [XLEN-1:0]         a_q, b_q;
  logic [XLEN-1:0]         rsp_data_q;
  logic                    rsp_flag_q;

`ifndef MIRISCV_ALU_ARB_FIXED_PRIO_EN
  logic last_q;
`endif

  always_comb begin
    grant_idx = 1'b0;
`ifdef MIRISCV_ALU_ARB_FIXED_PRIO_EN
    grant_idx = ~req_valid_i[0];
`else
    // Contention goes to whoever was not granted last; a lone requester always wins.
    case (req_valid_i)
      2'b11:   grant_idx = ~last_q;
      2'b10:   grant_idx = 1'b1;
      default: grant_idx = 1'b0;
    endcase
`endif
  end

  assign grant       = (state_q == IDLE && !rst_i && |req_valid_i) ? {grant_idx, ~grant_idx} : 2'b00;
  assign accept      = |(req_valid_i & grant);
  assign rsp_done    = (state_q == RESP) && rsp_ready_i[owner_q];
  assign req_ready_o = grant;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= grant_idx;
        op_q    <= req_op_i[grant_idx*ALU_OP_WIDTH +: ALU_OP_WIDTH];
        a_q     <= req_a_i[grant_idx*XLEN +: XLEN];
        b_q     <= req_b_i[grant_idx*XLEN +: XLEN];
      end
      if (state_q == EXEC) begin
        rsp_data_q <= alu_result_i;
        rsp_flag_q <= alu_flag_i;
      end
    end
  end

`ifndef MIRISCV_ALU_ARB_FIXED_PRIO_EN
  // Pointer starts at "last=1" so requester 0 wins the first contention.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'b1;
    else if (accept) last_q <= grant_idx;
  end
`endif

  // ALU inputs come straight from the operand registers so they never toggle outside EXEC.
  assign alu_op_o    = op_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign rsp_valid_o = (state_q == RESP) ? {owner_q, ~owner_q} : 2'b00;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_flag_o  = rsp_flag_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_miriscv_alu_arbiter.sv
// Bench for miriscv_alu_arbiter: transaction-level scoreboard checked every cycle plus directed literal checks.
module tb_miriscv_alu_arbiter;
  localparam int XLEN = 32;
  localparam int OPW  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        req_valid_i = '0;
  logic [1:0]        req_ready_o;
  logic [2*OPW-1:0]  req_op_i = '0;
  logic [2*XLEN-1:0] req_a_i = '0;
  logic [2*XLEN-1:0] req_b_i = '0;
  logic [OPW-1:0]    alu_op_o;
  logic [XLEN-1:0]   alu_a_o, alu_b_o;
  logic [XLEN-1:0]   alu_result;
  logic              alu_flag;
  logic [1:0]        rsp_valid_o;
  logic [1:0]        rsp_ready_i = 2'b11;
  logic [XLEN-1:0]   rsp_data_o;
  logic              rsp_flag_o;
  logic [1:0]        dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  miriscv_alu_arbiter #(.XLEN(XLEN), .ALU_OP_WIDTH(OPW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result), .alu_flag_i(alu_flag),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_flag_o(rsp_flag_o),
    .dbg_state_o(dbg_state)
  );

  // ---------------- reference ALU (external to the DUT) ----------------
  function automatic logic [XLEN-1:0] ref_result(input logic [OPW-1:0] op, input logic [XLEN-1:0] a, b);
    case (op[2:0])
      3'h0:    return op[3] ? a - b : a + b;
      3'h3:    return (a < b) ? 32'd1 : 32'd0;
      3'h4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic ref_flag(input logic [OPW-1:0] op, input logic [XLEN-1:0] a, b);
    return (op[2:0] == 3'h4) && ($signed(a) < $signed(b));
  endfunction

  assign alu_result = ref_result(alu_op_o, alu_a_o, alu_b_o);
  assign alu_flag   = ref_flag(alu_op_o, alu_a_o, alu_b_o);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_grant(input logic [1:0] v, input bit last);
    if (v == 2'b11) begin
`ifdef MIRISCV_ALU_ARB_FIXED_PRIO_EN
      return 2'b01;
`else
      return last ? 2'b01 : 2'b10;
`endif
    end
    return v;
  endfunction

  logic [XLEN-1:0] exp_q[$];
  logic            exp_fq[$];
  bit              busy = 1'b0;
  int              age = 0;
  bit              m_owner = 1'b0;
  bit              m_last = 1'b1;
  logic [OPW-1:0]  m_op = '0;
  logic [XLEN-1:0] m_a = '0, m_b = '0, m_rdata = '0;
  logic            m_rflag = 1'b0;
  int              n_accept = 0;

  // One request is in flight at a time: one cycle on the ALU, then a held response.
  always @(negedge clk) begin
    logic [1:0] g;
    int r;
    if (rst) begin
      chk("rst_ready", req_ready_o, 2'b00);
      chk("rst_rsp_valid", rsp_valid_o, 2'b00);
      chk("rst_rsp_data", rsp_data_o, 0);
      chk("rst_rsp_flag", rsp_flag_o, 0);
      chk("rst_alu_op", alu_op_o, 0);
      chk("rst_alu_a", alu_a_o, 0);
      chk("rst_alu_b", alu_b_o, 0);
      busy = 1'b0; m_last = 1'b1; m_op = '0; m_a = '0; m_b = '0;
      m_rdata = '0; m_rflag = 1'b0;
      exp_q.delete(); exp_fq.delete();
    end else begin
      chk("alu_op_hold", alu_op_o, m_op);
      chk("alu_a_hold", alu_a_o, m_a);
      chk("alu_b_hold", alu_b_o, m_b);
      if (!busy) begin
        g = exp_grant(req_valid_i, m_last);
        chk("idle_ready", req_ready_o, g);
        chk("idle_rsp_valid", rsp_valid_o, 2'b00);
        chk("idle_rsp_data", rsp_data_o, m_rdata);
        chk("idle_rsp_flag", rsp_flag_o, m_rflag);
        if (g != 2'b00) begin
          r = g[1] ? 1 : 0;
          busy = 1'b1; age = 0; m_owner = g[1]; m_last = g[1];
          m_op = req_op_i[r*OPW +: OPW];
          m_a  = req_a_i[r*XLEN +: XLEN];
          m_b  = req_b_i[r*XLEN +: XLEN];
          exp_q.push_back(ref_result(m_op, m_a, m_b));
          exp_fq.push_back(ref_flag(m_op, m_a, m_b));
          n_accept++;
        end
      end else if (age == 0) begin
        chk("exec_ready", req_ready_o, 2'b00);
        chk("exec_rsp_valid", rsp_valid_o, 2'b00);
        chk("exec_rsp_data", rsp_data_o, m_rdata);
        m_rdata = exp_q.pop_front();
        m_rflag = exp_fq.pop_front();
        age = 1;
      end else begin
        chk("resp_ready", req_ready_o, 2'b00);
        chk("resp_valid", rsp_valid_o, m_owner ? 2'b10 : 2'b01);
        chk("resp_data", rsp_data_o, m_rdata);
        chk("resp_flag", rsp_flag_o, m_rflag);
        if (rsp_ready_i[m_owner]) busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_req(input int r, input logic [OPW-1:0] op, input logic [XLEN-1:0] a, b);
    req_op_i[r*OPW +: OPW]  = op;
    req_a_i[r*XLEN +: XLEN] = a;
    req_b_i[r*XLEN +: XLEN] = b;
    req_valid_i[r]          = 1'b1;
  endtask

  // Returns #1 after the accepting edge (DUT now executing) with valid dropped.
  task automatic wait_accept(input int r);
    int n = 0;
    forever begin
      @(negedge clk);
      if (req_valid_i[r] && req_ready_o[r]) break;
      n++;
      if (n > 20) begin
        checks++; errors++;
        $display("FAIL accept_timeout req%0d actual=not_accepted expected=accepted", r);
        break;
      end
    end
    step();
    req_valid_i[r] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  int         na;
  int         k;
  logic [3:0] grants;
  logic [3:0] grants_exp;

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();

    // Basic ADD 5+7: ALU driven one cycle after accept, response the cycle after.
    drive_req(0, 4'h0, 32'd5, 32'd7);
    wait_accept(0);
    chk("t2_alu_a", alu_a_o, 32'd5);
    step();
    chk("t2_rsp_valid", rsp_valid_o, 2'b01);
    chk("t2_rsp_data", rsp_data_o, 32'd12);
    step();
    chk("t2_back_idle", rsp_valid_o, 2'b00);
    step();

    // Reset in the middle of EXEC discards the op.
    drive_req(0, 4'h0, 32'd5, 32'd7);
    wait_accept(0);
    req_valid_i = 2'b01;
    rst = 1'b1;
    #2;
    chk("t1_rsp_valid", rsp_valid_o, 2'b00);
    chk("t1_rsp_data", rsp_data_o, 0);
    chk("t1_alu_a", alu_a_o, 0);
    chk("t1_ready_in_rst", req_ready_o, 2'b00);
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_ready_follows", req_ready_o, 2'b01);
    step();
    req_valid_i = 2'b00;
    repeat (4) step();

    // Continuous contention: grant pattern from a fresh pointer.
    do_reset();
    drive_req(0, 4'h0, 32'd1, 32'd2);
    drive_req(1, 4'h8, 32'd10, 32'd3);
    k = 0;
    grants = '0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      @(negedge clk);
      if (req_ready_o != 2'b00) begin
        grants[k] = req_ready_o[1];
        k++;
      end
    end
    step();
    req_valid_i = 2'b00;
    chk("t3_grant_count", k, 4);
`ifdef MIRISCV_ALU_ARB_FIXED_PRIO_EN
    grants_exp = 4'b0000;
`else
    grants_exp = 4'b1010;
`endif
    chk("t3_grant_seq", grants, grants_exp);
    repeat (4) step();

    // SLTU 1 < 0xFFFFFFFF on requester 1, response stalled for 4 cycles.
    rsp_ready_i = 2'b01;
    drive_req(1, 4'h3, 32'd1, 32'hFFFF_FFFF);
    wait_accept(1);
    drive_req(0, 4'h0, 32'd3, 32'd4);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t4_rsp_valid", rsp_valid_o, 2'b10);
      chk("t4_rsp_data", rsp_data_o, 32'd1);
      chk("t4_req0_blocked", req_ready_o, 2'b00);
      step();
    end
    req_valid_i[0] = 1'b0;
    rsp_ready_i = 2'b11;
    step();
    chk("t4_retired", rsp_valid_o, 2'b00);
    step();

    // Signed LT branch compare; the non-owner's ready must not retire it.
    rsp_ready_i = 2'b01;
    drive_req(1, 4'h4, 32'hFFFF_FFFF, 32'd0);
    wait_accept(1);
    step();
    chk("t5_rsp_flag", rsp_flag_o, 1'b1);
    chk("t5_rsp_valid", rsp_valid_o, 2'b10);
    step();
    chk("t5_still_valid", rsp_valid_o, 2'b10);
    rsp_ready_i = 2'b10;
    step();
    chk("t5_retired", rsp_valid_o, 2'b00);
    rsp_ready_i = 2'b11;
    step();

    // A one-cycle req0 pulse while busy is never accepted.
    na = n_accept;
    drive_req(1, 4'h0, 32'd100, 32'd1);
    wait_accept(1);
    drive_req(0, 4'h0, 32'd9, 32'd9);
    @(negedge clk);
    chk("t6_pulse_ready", req_ready_o[0], 1'b0);
    step();
    req_valid_i[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_rsp0", rsp_valid_o[0], 1'b0);
    end
    chk("t6_accepts", n_accept - na, 1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
